// File: rtl/transport_pkg.sv
// Shared definitions for the transport-layer receiver: packet type codes,
// header field positions and the receive FSM state encoding.
package transport_pkg;

   typedef enum logic [1:0] {
      TYPE_NONE  = 2'b00,
      TYPE_VOICE = 2'b01,
      TYPE_TEXT  = 2'b10,
      TYPE_CTRL  = 2'b11
   } pkt_type_e;

   localparam int HDR_TYPE_MSB = 7;
   localparam int HDR_TYPE_LSB = 6;
   localparam int HDR_LEN_MSB  = 5;
   localparam int HDR_LEN_LSB  = 0;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PAYLOAD = 3'd1,
      ST_CHECK   = 3'd2,
      ST_DONE    = 3'd3,
      ST_DROP    = 3'd4
   } rcv_state_e;

endpackage

// File: rtl/transport_rcv_fifo.sv
// Word FIFO with a speculative write pointer and a commit pointer; only committed
// words are readable. Head word is held in a register (show-ahead) with commit bypass.
module transport_rcv_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en_i,
   input  logic [1:0]               wr_type_i,
   input  logic [DATA_W-1:0]        wr_data_i,
   input  logic                     commit_i,
   input  logic                     rollback_i,
   input  logic                     pop_i,
   output logic                     full_o,
   output logic [1:0]               rd_type_o,
   output logic [DATA_W-1:0]        rd_data_o,
   output logic [$clog2(DEPTH):0]   level_o
);
   localparam int AW = $clog2(DEPTH);
   typedef logic [AW:0] ptr_t;

   logic [DATA_W+1:0] mem_q [DEPTH];
   ptr_t              wr_q, cm_q, rd_q;
   ptr_t              wr_d, cm_d, rd_d, lvl_d;
   logic [1:0]        type_q, type_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              pop;
   logic [DATA_W+1:0] head;

   assign level_o   = cm_q - rd_q;
   assign full_o    = (ptr_t'(wr_q - rd_q) == ptr_t'(DEPTH));
   assign pop       = pop_i && (level_o != '0);
   assign rd_type_o = (level_o != '0) ? type_q : 2'b00;
   assign rd_data_o = data_q;

   always_comb begin
      wr_d   = rollback_i ? cm_q : ptr_t'(wr_q + ptr_t'(wr_en_i));
      cm_d   = commit_i ? ptr_t'(wr_q + ptr_t'(wr_en_i)) : cm_q;
      rd_d   = rd_q + ptr_t'(pop);
      lvl_d  = cm_d - rd_d;
      // The new head may be the very word being written and committed this cycle.
      head   = (wr_en_i && wr_q == rd_d) ? {wr_type_i, wr_data_i} : mem_q[rd_d[AW-1:0]];
      type_d = type_q;
      data_d = data_q;
      if (lvl_d != '0) begin
         type_d = head[DATA_W+1:DATA_W];
         data_d = head[DATA_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en_i) mem_q[wr_q[AW-1:0]] <= {wr_type_i, wr_data_i};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q   <= '0;
         cm_q   <= '0;
         rd_q   <= '0;
         type_q <= 2'b00;
         data_q <= '0;
      end else begin
         wr_q   <= wr_d;
         cm_q   <= cm_d;
         rd_q   <= rd_d;
         type_q <= type_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/transport_rcv_buf.sv
// Transport-layer receiver: parses framed byte packets into DATA_W words and releases
// only whole, valid packets to the session. Trailing checksum byte when TRANSPORT_CHECKSUM_EN.
module transport_rcv_buf
   import transport_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   rcvSignal,
   input  logic [7:0]             packetIn,
   input  logic                   sessionBusy,
   output logic [1:0]             sendingToSession,
   output logic [DATA_W-1:0]      data,
   output logic                   pktError,
   output logic [CNT_W-1:0]       dropCount,
   output logic [$clog2(DEPTH):0] fifoLevel,
   output logic [2:0]             dbgState
);
   localparam int BPW = DATA_W / 8;
   localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;

   rcv_state_e        state_q, state_d;
   logic [1:0]        type_q, type_d;
   logic [5:0]        cnt_q, cnt_d;
   logic [7:0]        csum_q, csum_d;
   logic [BW-1:0]     bidx_q, bidx_d;
   logic [DATA_W-1:0] wbuf_q, wbuf_d, word_nxt;
   logic              prev_q, err_q;
   logic [CNT_W-1:0]  drop_q;
   logic              wr_en, commit, err, fifo_full;

   assign dbgState  = state_q;
   assign pktError  = err_q;
   assign dropCount = drop_q;

   always_comb begin
      state_d = state_q;
      type_d  = type_q;
      cnt_d   = cnt_q;
      csum_d  = csum_q;
      bidx_d  = bidx_q;
      wbuf_d  = wbuf_q;
      wr_en   = 1'b0;
      commit  = 1'b0;
      err     = 1'b0;
      word_nxt = wbuf_q;
      for (int i = 0; i < BPW; i++)
         if (bidx_q == BW'(i)) word_nxt[DATA_W-8-8*i +: 8] = packetIn;

      case (state_q)
         ST_IDLE: begin
            // A header needs at least one idle cycle before it.
            if (rcvSignal && !prev_q) begin
               if (packetIn[HDR_TYPE_MSB:HDR_TYPE_LSB] == TYPE_NONE) begin
                  err = 1'b1;
               end else begin
                  type_d = packetIn[HDR_TYPE_MSB:HDR_TYPE_LSB];
                  cnt_d  = packetIn[HDR_LEN_MSB:HDR_LEN_LSB];
                  csum_d = packetIn;
                  bidx_d = '0;
                  wbuf_d = '0;
                  if (packetIn[HDR_LEN_MSB:HDR_LEN_LSB] != 6'd0) begin
                     state_d = ST_PAYLOAD;
                  end else begin
`ifdef TRANSPORT_CHECKSUM_EN
                     state_d = ST_CHECK;
`else
                     commit  = 1'b1;
                     state_d = ST_DONE;
`endif
                  end
               end
            end
         end
         ST_PAYLOAD: begin
            if (!rcvSignal) begin
               err = 1'b1;
            end else begin
               csum_d = csum_q ^ packetIn;
               cnt_d  = cnt_q - 6'd1;
               if (bidx_q == BW'(BPW-1) || cnt_q == 6'd1) begin
                  if (fifo_full) begin
                     err = 1'b1;
                  end else begin
                     wr_en  = 1'b1;
                     wbuf_d = '0;
                     bidx_d = '0;
                     if (cnt_q == 6'd1) begin
`ifdef TRANSPORT_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        commit  = 1'b1;
                        state_d = ST_DONE;
`endif
                     end
                  end
               end else begin
                  wbuf_d = word_nxt;
                  bidx_d = bidx_q + BW'(1);
               end
            end
         end
         ST_CHECK: begin
            if (rcvSignal && packetIn == csum_q) begin
               commit  = 1'b1;
               state_d = ST_DONE;
            end else begin
               err = 1'b1;
            end
         end
         ST_DONE, ST_DROP: begin
            if (!rcvSignal) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (err) state_d = ST_DROP;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         type_q  <= 2'b00;
         cnt_q   <= '0;
         csum_q  <= '0;
         bidx_q  <= '0;
         wbuf_q  <= '0;
         prev_q  <= 1'b1;  // ignore the tail of a packet cut by reset
         err_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         type_q  <= type_d;
         cnt_q   <= cnt_d;
         csum_q  <= csum_d;
         bidx_q  <= bidx_d;
         wbuf_q  <= wbuf_d;
         prev_q  <= rcvSignal;
         err_q   <= err;
         if (err && drop_q != '1) drop_q <= drop_q + CNT_W'(1);
      end
   end

   transport_rcv_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .wr_en_i    (wr_en),
      .wr_type_i  (type_q),
      .wr_data_i  (word_nxt),
      .commit_i   (commit),
      .rollback_i (err),
      .pop_i      (!sessionBusy),
      .full_o     (fifo_full),
      .rd_type_o  (sendingToSession),
      .rd_data_o  (data),
      .level_o    (fifoLevel)
   );

endmodule

// File: tb/tb_transport_rcv_buf.sv
// Directed table-driven bench for transport_rcv_buf (DEPTH=4, DATA_W=16), plus
// hand-written sequences for latency, checksum, empty payload and mid-packet reset.
module tb_transport_rcv_buf;
   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int CW    = 8;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset, rcv, busy;
   logic [7:0]    pin;
   logic [1:0]    send;
   logic [DW-1:0] data;
   logic          err;
   logic [CW-1:0] drop;
   logic [LW-1:0] lvl;
   logic [2:0]    st;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic       r;
      logic [7:0] b;
      logic       bz;
      logic       chk;  // 0: outcome of this cycle differs between checksum/no-checksum builds
      logic [1:0] s;
      logic [15:0] d;
      logic       e;
      logic [2:0] l;
      logic [7:0] c;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   transport_rcv_buf #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clk              (clk),
      .reset            (reset),
      .rcvSignal        (rcv),
      .packetIn         (pin),
      .sessionBusy      (busy),
      .sendingToSession (send),
      .data             (data),
      .pktError         (err),
      .dropCount        (drop),
      .fifoLevel        (lvl),
      .dbgState         (st)
   );

   task automatic add(input logic r, input logic [7:0] b, input logic bz, input logic chk,
                      input logic [1:0] s, input logic [15:0] d, input logic e,
                      input logic [2:0] l, input logic [7:0] c);
      vec_t v;
      v.r = r; v.b = b; v.bz = bz; v.chk = chk;
      v.s = s; v.d = d; v.e = e; v.l = l; v.c = c;
      tbl.push_back(v);
   endtask

   task automatic step(input logic r, input logic [7:0] b, input logic bz);
      rcv = r; pin = b; busy = bz;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; rcv = 1'b0; pin = 8'h00; busy = 1'b0;
      @(posedge clk); #1;
      check("reset_state", {send, data, err, lvl, drop}, 32'h0);
      reset = 1'b0;

      // fields: rcv byte busy chk | send data err level drops
      // voice 44: 12 34 56 78 (+cs 4C)
      add(0,8'h00,0,1, 0,16'h0000,0,0,0);
      add(1,8'h44,0,1, 0,16'h0000,0,0,0);
      add(1,8'h12,0,1, 0,16'h0000,0,0,0);
      add(1,8'h34,0,1, 0,16'h0000,0,0,0);
      add(1,8'h56,0,1, 0,16'h0000,0,0,0);
      add(1,8'h78,0,0, 0,16'h0000,0,0,0);
      add(1,8'h4C,1,1, 1,16'h1234,0,2,0);
      add(0,8'h00,0,1, 1,16'h5678,0,1,0);
      add(0,8'h00,0,1, 0,16'h5678,0,0,0);
      // text 83: AA BB CC (+cs 5E), held by busy then drained
      add(1,8'h83,1,1, 0,16'h5678,0,0,0);
      add(1,8'hAA,1,1, 0,16'h5678,0,0,0);
      add(1,8'hBB,1,1, 0,16'h5678,0,0,0);
      add(1,8'hCC,1,0, 0,16'h5678,0,0,0);
      add(1,8'h5E,1,1, 2,16'hAABB,0,2,0);
      add(0,8'h00,1,1, 2,16'hAABB,0,2,0);
      add(0,8'h00,0,1, 2,16'hCC00,0,1,0);
      add(0,8'h00,0,1, 0,16'hCC00,0,0,0);
      // truncated voice packet
      add(1,8'h44,0,1, 0,16'hCC00,0,0,0);
      add(1,8'h12,0,1, 0,16'hCC00,0,0,0);
      add(1,8'h34,0,1, 0,16'hCC00,0,0,0);
      add(0,8'h00,0,1, 0,16'hCC00,1,0,1);
      add(0,8'h00,0,1, 0,16'hCC00,0,0,1);
      // one committed word, then a 4-word packet overflows DEPTH=4
      add(1,8'h41,1,1, 0,16'hCC00,0,0,1);
      add(1,8'h9A,1,0, 0,16'hCC00,0,0,1);
      add(1,8'hDB,1,1, 1,16'h9A00,0,1,1);
      add(0,8'h00,1,1, 1,16'h9A00,0,1,1);
      add(1,8'h48,1,1, 1,16'h9A00,0,1,1);
      for (int i = 1; i <= 7; i++) add(1,8'(i),1,1, 1,16'h9A00,0,1,1);
      add(1,8'h08,1,1, 1,16'h9A00,1,1,2);
      add(0,8'h00,1,1, 1,16'h9A00,0,1,2);
      add(0,8'h00,0,1, 0,16'h9A00,0,0,2);
      // invalid type header, trailing bytes ignored
      add(1,8'h02,0,1, 0,16'h9A00,1,0,3);
      add(1,8'hAA,0,1, 0,16'h9A00,0,0,3);
      add(0,8'h00,0,1, 0,16'h9A00,0,0,3);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].r, tbl[i].b, tbl[i].bz);
         if (tbl[i].chk)
            check($sformatf("vec%0d", i), {send, data, err, 3'(lvl), drop},
                  {tbl[i].s, tbl[i].d, tbl[i].e, tbl[i].l, tbl[i].c});
      end

      // first word visible one clock after the frame's last byte
      step(1, 8'h41, 0);
      check("lat_pre", {30'h0, send}, 32'h0);
      step(1, 8'h9A, 0);
`ifdef TRANSPORT_CHECKSUM_EN
      check("lat_pre_cs", {30'h0, send}, 32'h0);
      step(1, 8'hDB, 0);
`endif
      check("lat_first", {send, data}, {2'b01, 16'h9A00});
      step(0, 8'h00, 0);
      check("lat_drain", {send, 3'(lvl)}, 32'h0);

      // 42: 11 22 with good checksum 71 in the checksum build
      step(1, 8'h42, 1); step(1, 8'h11, 1); step(1, 8'h22, 1);
`ifdef TRANSPORT_CHECKSUM_EN
      step(1, 8'h71, 1);
`endif
      check("pkt_1122", {send, data, 3'(lvl), err}, {2'b01, 16'h1122, 3'd1, 1'b0});
      step(0, 8'h00, 0);
      check("pkt_1122_pop", {send, 3'(lvl)}, 32'h0);
`ifdef TRANSPORT_CHECKSUM_EN
      step(1, 8'h42, 1); step(1, 8'h11, 1); step(1, 8'h22, 1); step(1, 8'h70, 1);
      check("cs_bad", {err, drop, 3'(lvl)}, {1'b1, 8'd4, 3'd0});
      step(0, 8'h00, 1);
      check("cs_bad_after", {send, err, 3'(lvl)}, 32'h0);
`endif

      // empty payload: nothing written, no error
      step(1, 8'h40, 0);
`ifdef TRANSPORT_CHECKSUM_EN
      step(1, 8'h40, 0);
`endif
      step(0, 8'h00, 0);
      check("empty_pkt", {send, err, 3'(lvl)}, 32'h0);

      // reset mid-payload, then a clean packet
      step(1, 8'h42, 0); step(1, 8'h55, 0);
      reset = 1'b1;
      step(1, 8'h66, 0);
      check("mid_reset", {send, data, err, lvl, drop}, 32'h0);
      reset = 1'b0;
      step(1, 8'h77, 0);
      check("post_reset_tail", {send, err, 3'(lvl)}, 32'h0);
      step(0, 8'h00, 1);
      step(1, 8'h42, 1); step(1, 8'h11, 1); step(1, 8'h22, 1);
`ifdef TRANSPORT_CHECKSUM_EN
      step(1, 8'h71, 1);
`endif
      check("clean_after_reset", {send, data, 3'(lvl), drop}, {2'b01, 16'h1122, 3'd1, 8'd0});
      step(0, 8'h00, 0);
      check("clean_drain", {send, 3'(lvl), drop}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
